// File: rtl/me_pkg.sv
// State encoding and geometry-derived width helpers for the full-search ME controller.
// All widths come from the block/window geometry, so no counter can overflow.
package me_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD_TB,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // $clog2 that never yields a zero-width vector for degenerate geometries.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sad_width(input int tb_length, input int pe_out_width);
        return idx_width(tb_length * tb_length) + pe_out_width;
    endfunction

    function automatic int cand_span(input int sw_edge, input int tb_length);
        return sw_edge - tb_length + 1;
    endfunction

    function automatic int cnt_width(input int ncand);
        return $clog2(ncand + 1);
    endfunction

endpackage

// File: rtl/me_min_tracker.sv
// Candidate raster counters and running-minimum/early-exit tracker; results registered, zero latency on compare.
// No backpressure: every accepted SAD is consumed the cycle it is presented.
module me_min_tracker
    import me_pkg::*;
#(
    parameter int SAD_WIDTH = 12,
    parameter int CX        = 5,
    parameter int CY        = 3,
    localparam int NCAND     = CX * CY,
    localparam int CNT_WIDTH = cnt_width(NCAND),
    localparam int MVX_W     = idx_width(CX),
    localparam int MVY_W     = idx_width(CY)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 acc,
    input  logic                 cfg_early_en,
    input  logic [SAD_WIDTH-1:0] cfg_thresh,
    input  logic [SAD_WIDTH-1:0] sad,
    output logic                 cand_last,
    output logic                 cand_early,
    output logic                 early_hit,
    output logic [SAD_WIDTH-1:0] min_sad,
    output logic [MVX_W-1:0]     min_mvx,
    output logic [MVY_W-1:0]     min_mvy,
    output logic [CNT_WIDTH-1:0] min_cnt,
    output logic [CNT_WIDTH-1:0] n_eval
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NCAND - 1);
    localparam logic [MVX_W-1:0]     MVX_LAST = MVX_W'(CX - 1);

    logic                 early_en_q, early_en_d;
    logic [SAD_WIDTH-1:0] thresh_q, thresh_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [MVX_W-1:0]     mvx_q, mvx_d;
    logic [MVY_W-1:0]     mvy_q, mvy_d;
    logic [SAD_WIDTH-1:0] min_sad_q, min_sad_d;
    logic [MVX_W-1:0]     min_mvx_q, min_mvx_d;
    logic [MVY_W-1:0]     min_mvy_q, min_mvy_d;
    logic [CNT_WIDTH-1:0] min_cnt_q, min_cnt_d;
    logic                 early_hit_q, early_hit_d;
    logic                 upd;

    assign cand_last  = acc && (cnt_q == CNT_LAST);
    assign cand_early = acc && early_en_q && (sad <= thresh_q);
    // Strict less-than keeps the earliest raster candidate on ties.
    assign upd        = acc && ((sad < min_sad_q) || cand_early);

    always_comb begin
        early_en_d  = early_en_q;
        thresh_d    = thresh_q;
        cnt_d       = cnt_q;
        mvx_d       = mvx_q;
        mvy_d       = mvy_q;
        min_sad_d   = min_sad_q;
        min_mvx_d   = min_mvx_q;
        min_mvy_d   = min_mvy_q;
        min_cnt_d   = min_cnt_q;
        early_hit_d = early_hit_q;
        if (start) begin
            early_en_d  = cfg_early_en;
            thresh_d    = cfg_thresh;
            cnt_d       = '0;
            mvx_d       = '0;
            mvy_d       = '0;
            min_sad_d   = '1;
            min_mvx_d   = '0;
            min_mvy_d   = '0;
            min_cnt_d   = '0;
            early_hit_d = 1'b0;
        end else if (acc) begin
            cnt_d = cnt_q + 1'b1;
            // The position is held on the final candidate so mvy never steps past CY-1.
            if (!cand_last) begin
                if (mvx_q == MVX_LAST) begin
                    mvx_d = '0;
                    mvy_d = mvy_q + 1'b1;
                end else begin
                    mvx_d = mvx_q + 1'b1;
                end
            end
            if (upd) begin
                min_sad_d = sad;
                min_mvx_d = mvx_q;
                min_mvy_d = mvy_q;
                min_cnt_d = cnt_q;
            end
            if (cand_early) begin
                early_hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_en_q  <= 1'b0;
            thresh_q    <= '0;
            cnt_q       <= '0;
            mvx_q       <= '0;
            mvy_q       <= '0;
            min_sad_q   <= '1;
            min_mvx_q   <= '0;
            min_mvy_q   <= '0;
            min_cnt_q   <= '0;
            early_hit_q <= 1'b0;
        end else begin
            early_en_q  <= early_en_d;
            thresh_q    <= thresh_d;
            cnt_q       <= cnt_d;
            mvx_q       <= mvx_d;
            mvy_q       <= mvy_d;
            min_sad_q   <= min_sad_d;
            min_mvx_q   <= min_mvx_d;
            min_mvy_q   <= min_mvy_d;
            min_cnt_q   <= min_cnt_d;
            early_hit_q <= early_hit_d;
        end
    end

    assign early_hit = early_hit_q;
    assign min_sad   = min_sad_q;
    assign min_mvx   = min_mvx_q;
    assign min_mvy   = min_mvy_q;
    assign min_cnt   = min_cnt_q;
    assign n_eval    = cnt_q;

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search ME sequencer: clear, TB load, SW raster scan, drain, then holds the minimum-SAD result on ack.
// Ack after 1 + TB^2 + SW area + PE pipeline + 1 cycles; no backpressure, req withdrawal aborts.
module me_search_ctrl
    import me_pkg::*;
#(
    parameter int TB_LENGTH    = 16,
    parameter int SW_WIDTH     = 64,
    parameter int SW_HEIGHT    = 64,
    parameter int PE_OUT_WIDTH = 8,
    parameter int MEM_LATENCY  = 1,
    localparam int SAD_WIDTH = sad_width(TB_LENGTH, PE_OUT_WIDTH),
    localparam int CX        = cand_span(SW_WIDTH, TB_LENGTH),
    localparam int CY        = cand_span(SW_HEIGHT, TB_LENGTH),
    localparam int CNT_WIDTH = cnt_width(CX * CY),
    localparam int TB_AW     = idx_width(TB_LENGTH * TB_LENGTH),
    localparam int SW_AW     = idx_width(SW_WIDTH * SW_HEIGHT),
    localparam int MVX_W     = idx_width(CX),
    localparam int MVY_W     = idx_width(CY)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 cfg_early_en,
    input  logic [SAD_WIDTH-1:0] cfg_thresh,
    input  logic                 sad_valid,
    input  logic [SAD_WIDTH-1:0] sad,
    output logic                 clr,
    output logic [TB_AW-1:0]     addr_tb,
    output logic [SW_AW-1:0]     addr_sw,
    output logic                 en_pearray_tb,
    output logic                 en_pearray_sw,
    output logic                 busy,
    output logic                 ack,
    output logic                 early_hit,
    output logic [SAD_WIDTH-1:0] min_sad,
    output logic [MVX_W-1:0]     min_mvx,
    output logic [MVY_W-1:0]     min_mvy,
    output logic [CNT_WIDTH-1:0] min_cnt,
    output logic [CNT_WIDTH-1:0] n_eval
);

    localparam logic [TB_AW-1:0] TB_LAST = TB_AW'(TB_LENGTH * TB_LENGTH - 1);
    localparam logic [SW_AW-1:0] SW_LAST = SW_AW'(SW_WIDTH * SW_HEIGHT - 1);

    state_t                 state_q, state_d;
    logic                   clr_q, clr_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic                   aen_tb_q, aen_tb_d;
    logic                   aen_sw_q, aen_sw_d;
    logic [TB_AW-1:0]       addr_tb_q, addr_tb_d;
    logic [SW_AW-1:0]       addr_sw_q, addr_sw_d;
    logic [MEM_LATENCY-1:0] pipe_tb_q, pipe_tb_d;
    logic [MEM_LATENCY-1:0] pipe_sw_q, pipe_sw_d;
    logic                   start, sad_acc, cand_last, cand_early;

    assign start   = (state_q == ST_IDLE) && req;
    assign sad_acc = sad_valid && ((state_q == ST_SCAN) || (state_q == ST_DRAIN));

    always_comb begin
        state_d   = state_q;
        addr_tb_d = addr_tb_q;
        addr_sw_d = addr_sw_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CLR;
                    addr_tb_d = '0;
                    addr_sw_d = '0;
                end
            end
            ST_CLR:     state_d = ST_LOAD_TB;
            ST_LOAD_TB: begin
                if (addr_tb_q == TB_LAST) state_d = ST_SCAN;
                else                      addr_tb_d = addr_tb_q + 1'b1;
            end
            ST_SCAN: begin
                if (addr_sw_q == SW_LAST) state_d = ST_DRAIN;
                else                      addr_sw_d = addr_sw_q + 1'b1;
            end
            ST_DRAIN:   state_d = ST_DRAIN;
            ST_DONE: begin
                if (!req) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
        if (cand_last || cand_early) begin
            state_d = ST_DONE;
        end
        // Withdrawal of req outranks a simultaneous finish: the requester has gone away.
        if (busy_q && !req) begin
            state_d = ST_IDLE;
        end

        clr_d    = (state_d == ST_CLR);
        busy_d   = state_d inside {ST_CLR, ST_LOAD_TB, ST_SCAN, ST_DRAIN};
        ack_d    = (state_d == ST_DONE);
        aen_tb_d = (state_d == ST_LOAD_TB);
        aen_sw_d = (state_d == ST_SCAN);

        // The pel-valid delay line is flushed whenever the search ends, so nothing leaks past DONE or an abort.
        pipe_tb_d    = pipe_tb_q << 1;
        pipe_tb_d[0] = aen_tb_q;
        pipe_sw_d    = pipe_sw_q << 1;
        pipe_sw_d[0] = aen_sw_q;
        if (!busy_d) begin
            pipe_tb_d = '0;
            pipe_sw_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            aen_tb_q  <= 1'b0;
            aen_sw_q  <= 1'b0;
            addr_tb_q <= '0;
            addr_sw_q <= '0;
            pipe_tb_q <= '0;
            pipe_sw_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            aen_tb_q  <= aen_tb_d;
            aen_sw_q  <= aen_sw_d;
            addr_tb_q <= addr_tb_d;
            addr_sw_q <= addr_sw_d;
            pipe_tb_q <= pipe_tb_d;
            pipe_sw_q <= pipe_sw_d;
        end
    end

    me_min_tracker #(
        .SAD_WIDTH (SAD_WIDTH),
        .CX        (CX),
        .CY        (CY)
    ) u_min_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .acc          (sad_acc),
        .cfg_early_en (cfg_early_en),
        .cfg_thresh   (cfg_thresh),
        .sad          (sad),
        .cand_last    (cand_last),
        .cand_early   (cand_early),
        .early_hit    (early_hit),
        .min_sad      (min_sad),
        .min_mvx      (min_mvx),
        .min_mvy      (min_mvy),
        .min_cnt      (min_cnt),
        .n_eval       (n_eval)
    );

    assign clr           = clr_q;
    assign busy          = busy_q;
    assign ack           = ack_q;
    assign addr_tb       = addr_tb_q;
    assign addr_sw       = addr_sw_q;
    assign en_pearray_tb = pipe_tb_q[MEM_LATENCY-1];
    assign en_pearray_sw = pipe_sw_q[MEM_LATENCY-1];

endmodule

// File: tb/tb_me_search_ctrl.sv
// Scoreboard bench for me_search_ctrl with a 4x4 block in an 8x6 window (15 candidates).
// Stimulus pushes expected results; a negedge monitor checks them and the address/enable timing on each ack.
module tb_me_search_ctrl;

    localparam int SADW = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req = 1'b0;
    logic            cfg_early_en = 1'b0;
    logic [SADW-1:0] cfg_thresh = '0;
    logic            sad_valid = 1'b0;
    logic [SADW-1:0] sad = '0;
    logic            clr, en_pearray_tb, en_pearray_sw, busy, ack, early_hit;
    logic [3:0]      addr_tb;
    logic [5:0]      addr_sw;
    logic [SADW-1:0] min_sad;
    logic [2:0]      min_mvx;
    logic [1:0]      min_mvy;
    logic [3:0]      min_cnt, n_eval;

    me_search_ctrl #(
        .TB_LENGTH(4), .SW_WIDTH(8), .SW_HEIGHT(6), .PE_OUT_WIDTH(8), .MEM_LATENCY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cfg_early_en(cfg_early_en), .cfg_thresh(cfg_thresh),
        .sad_valid(sad_valid), .sad(sad), .clr(clr), .addr_tb(addr_tb), .addr_sw(addr_sw),
        .en_pearray_tb(en_pearray_tb), .en_pearray_sw(en_pearray_sw), .busy(busy), .ack(ack),
        .early_hit(early_hit), .min_sad(min_sad), .min_mvx(min_mvx), .min_mvy(min_mvy),
        .min_cnt(min_cnt), .n_eval(n_eval)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sad; int cnt; int mvx; int mvy; int neval; int early; int timing;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    int v_desc[15]  = '{150, 140, 130, 120, 110, 100, 90, 80, 70, 60, 50, 40, 30, 20, 10};
    int v_flat[15]  = '{default: 40};
    int v_two7[15]  = '{100, 100, 100, 7, 100, 100, 100, 100, 100, 7, 100, 100, 100, 100, 100};
    int v_early[15] = '{90, 80, 70, 60, 50, 40, 20, 5, 5, 5, 5, 5, 5, 5, 5};

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_exp(input int s, input int c, input int x, input int y,
                            input int ne, input int e, input int t);
        exp_t e_new;
        e_new = '{sad: s, cnt: c, mvx: x, mvy: y, neval: ne, early: e, timing: t};
        exp_q.push_back(e_new);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_clr"}, int'(clr), 0);
        chk({tag, "_addr_tb"}, int'(addr_tb), 0);
        chk({tag, "_addr_sw"}, int'(addr_sw), 0);
        chk({tag, "_en_tb"}, int'(en_pearray_tb), 0);
        chk({tag, "_en_sw"}, int'(en_pearray_sw), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_early_hit"}, int'(early_hit), 0);
        chk({tag, "_min_sad"}, int'(min_sad), 4095);
        chk({tag, "_min_mvx"}, int'(min_mvx), 0);
        chk({tag, "_min_mvy"}, int'(min_mvy), 0);
        chk({tag, "_min_cnt"}, int'(min_cnt), 0);
        chk({tag, "_n_eval"}, int'(n_eval), 0);
    endtask

    // Raise req, wait for the scan to reach the PE array, then feed SADs spaced 4 cycles apart.
    task automatic run(input int vals[15], input int nfeed, input bit een, input int th);
        int n;
        cfg_early_en = een;
        cfg_thresh   = SADW'(th);
        req          = 1'b1;
        @(negedge clk);
        n = 0;
        while (!en_pearray_sw && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!en_pearray_sw) chk("scan_start_timeout", 0, 1);
        for (int i = 0; i < nfeed; i++) begin
            sad_valid = 1'b1;
            sad       = SADW'(vals[i]);
            @(negedge clk);
            sad_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic finish(input int esad, input int eneval);
        int n;
        n = 0;
        while (!ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ack) chk("ack_timeout", 0, 1);
        for (int k = 0; k < 3; k++) begin
            chk("ack_hold", int'(ack), 1);
            chk("min_sad_stable", int'(min_sad), esad);
            @(negedge clk);
        end
        chk("n_eval_stable", int'(n_eval), eneval);
        req = 1'b0;
        @(negedge clk);
        chk("ack_fall", int'(ack), 0);
        @(negedge clk);
    endtask

    // Monitor state
    logic       busy_p, ack_p;
    logic [3:0] prev_tb;
    logic [5:0] prev_sw;
    int         cyc, clr_cnt, tb_cnt, sw_cnt, seq_err, first_tb, first_sw;
    exp_t       mon_e;

    initial begin
        busy_p = 1'b0; ack_p = 1'b0; prev_tb = '0; prev_sw = '0;
        cyc = 0; clr_cnt = 0; tb_cnt = 0; sw_cnt = 0; seq_err = 0; first_tb = -1; first_sw = -1;
        forever begin
            @(negedge clk);
            if (busy && !busy_p) begin
                cyc = 0; clr_cnt = 0; tb_cnt = 0; sw_cnt = 0; seq_err = 0; first_tb = -1; first_sw = -1;
            end else begin
                cyc++;
            end
            if (clr) clr_cnt++;
            if (en_pearray_tb) begin
                if (first_tb < 0) first_tb = cyc;
                if (int'(prev_tb) != tb_cnt) seq_err++;
                tb_cnt++;
            end
            if (en_pearray_sw) begin
                if (first_sw < 0) first_sw = cyc;
                if (int'(prev_sw) != sw_cnt) seq_err++;
                sw_cnt++;
            end
            if (ack && !ack_p) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("min_sad", int'(min_sad), mon_e.sad);
                    chk("min_cnt", int'(min_cnt), mon_e.cnt);
                    chk("min_mvx", int'(min_mvx), mon_e.mvx);
                    chk("min_mvy", int'(min_mvy), mon_e.mvy);
                    chk("n_eval", int'(n_eval), mon_e.neval);
                    chk("early_hit", int'(early_hit), mon_e.early);
                    chk("busy_in_done", int'(busy), 0);
                    if (mon_e.timing != 0) begin
                        chk("clr_cycles", clr_cnt, 1);
                        chk("tb_beats", tb_cnt, 16);
                        chk("sw_beats", sw_cnt, 48);
                        chk("addr_sequence_errors", seq_err, 0);
                        chk("tb_first_cycle", first_tb, 2);
                        chk("sw_first_cycle", first_sw, 18);
                        chk("addr_sw_saturated", int'(addr_sw), 47);
                    end
                end
            end
            busy_p  = busy;
            ack_p   = ack;
            prev_tb = addr_tb;
            prev_sw = addr_sw;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Descending SADs, early exit disabled although every SAD is under the threshold
        push_exp(10, 14, 4, 2, 15, 0, 1);
        run(v_desc, 15, 1'b0, 200);
        finish(10, 15);

        // All equal: first candidate wins; threshold one below the SAD never fires
        push_exp(40, 0, 0, 0, 15, 0, 1);
        run(v_flat, 15, 1'b1, 39);
        finish(40, 15);

        // Two equal minima: the earlier one is kept
        push_exp(7, 3, 3, 0, 15, 0, 1);
        run(v_two7, 15, 1'b1, 5);
        finish(7, 15);

        // Early exit on SAD equal to the threshold; later SADs must be ignored
        push_exp(20, 6, 1, 1, 7, 1, 0);
        run(v_early, 15, 1'b1, 20);
        finish(20, 7);

        // Abort mid-scan
        run(v_desc, 3, 1'b0, 200);
        chk("pre_abort_busy", int'(busy), 1);
        req = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_en_tb", int'(en_pearray_tb), 0);
        chk("abort_en_sw", int'(en_pearray_sw), 0);
        chk("abort_ack", int'(ack), 0);
        repeat (4) @(negedge clk);
        chk("abort_ack_later", int'(ack), 0);
        push_exp(10, 14, 4, 2, 15, 0, 1);
        run(v_desc, 15, 1'b0, 200);
        finish(10, 15);

        // Asynchronous reset while draining
        run(v_desc, 14, 1'b0, 200);
        chk("drain_busy", int'(busy), 1);
        chk("drain_en_sw", int'(en_pearray_sw), 0);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(40, 0, 0, 0, 15, 0, 1);
        run(v_flat, 15, 1'b0, 0);
        finish(40, 15);

        chk("scoreboard_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
